// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        SYS     = 2'd1,
        PCFAULT = 2'd2,
        WDOG    = 2'd3
    } halt_cause_t;

    localparam logic [XLEN-1:0] OP_ECALL  = 32'h0000_0073;
    localparam logic [XLEN-1:0] OP_EBREAK = 32'h0010_0073;

    // True for the two environment-call encodings that stop the core.
    function automatic logic is_system_halt(input logic [XLEN-1:0] word);
        return (word == OP_ECALL) || (word == OP_EBREAK);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Clear wins over enable so a restart always begins from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Sequences instruction fetch: imem loading, start/stall/redirect and halt detection.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned MAX_CYCLES = 0,
    localparam int unsigned AW        = $clog2(IMEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    input  logic [31:0]   pc,
    input  logic [31:0]   instr,
    input  logic          br_taken,
    input  logic [31:0]   br_target,
    input  logic          stall,
    output logic          pc_update,
    output logic [31:0]   pc_new,
    output logic          core_en,
    output logic          halted,
    output logic [1:0]    halt_cause,
    output logic [31:0]   cycle_count,
    output logic [31:0]   retired_count
);

    state_t        r_state;
    state_t        w_state_nxt;
    halt_cause_t   r_halt_cause;
    halt_cause_t   w_cause;
    logic          r_imem_we;
    logic [AW-1:0] r_imem_waddr;
    logic [31:0]   r_imem_wdata;
    logic          r_core_en;
    logic          r_halted;

    logic w_run;
    logic w_load_fire;
    logic w_start_ok;
    logic w_pc_fault;
    logic w_sys;
    logic w_wdog;
    logic w_halt;
    logic w_retire;

    assign w_run       = (r_state == RUN);
    assign load_ready  = !w_run;
    assign w_load_fire = load_valid && load_ready;

    // A start is only taken once no loader write can still be landing in imem.
    assign w_start_ok = start && !w_run && !load_valid && !r_imem_we;

    assign w_pc_fault = !stall && ((pc[1:0] != 2'b00) || ((pc >> 2) >= 32'(IMEM_WORDS)));
    assign w_sys      = !stall && is_system_halt(instr);
    assign w_wdog     = (MAX_CYCLES != 0) && (cycle_count == 32'(MAX_CYCLES - 1));

    always_comb begin
        w_cause = NONE;
        if (w_pc_fault) begin
            w_cause = PCFAULT;
        end else if (w_sys) begin
            w_cause = SYS;
        end else if (w_wdog) begin
            w_cause = WDOG;
        end
    end

    assign w_halt = w_run && (w_cause != NONE);

    // Next state and fetch redirect; holding the current pc is the default.
    always_comb begin
        w_state_nxt = r_state;
        pc_update   = 1'b1;
        pc_new      = pc;
        w_retire    = 1'b0;
        unique case (r_state)
            IDLE: begin
                pc_new = RESET_PC;
                if (w_start_ok) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_halt) begin
                    w_state_nxt = HALT;
                    w_retire    = (w_cause == SYS);
                end else if (stall) begin
                    w_retire = 1'b0;
                end else if (br_taken) begin
                    pc_new   = br_target;
                    w_retire = 1'b1;
                end else begin
                    pc_update = 1'b0;
                    w_retire  = 1'b1;
                end
            end
            HALT: begin
                if (w_start_ok) begin
                    pc_new      = RESET_PC;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Loader write port: one-cycle registered pass-through into imem.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_imem_we <= w_load_fire;
            if (w_load_fire) begin
                r_imem_waddr <= load_addr;
                r_imem_wdata <= load_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_core_en    <= 1'b0;
            r_halted     <= 1'b0;
            r_halt_cause <= NONE;
        end else begin
            r_core_en <= (w_state_nxt == RUN);
            r_halted  <= (w_state_nxt == HALT);
            if (w_start_ok) begin
                r_halt_cause <= NONE;
            end else if (w_halt) begin
                r_halt_cause <= w_cause;
            end
        end
    end

    sat_counter #(
        .W(32)
    ) u_cycle_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_start_ok),
        .i_en   (w_run),
        .o_count(cycle_count)
    );

    sat_counter #(
        .W(32)
    ) u_retired_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_start_ok),
        .i_en   (w_run && w_retire),
        .o_count(retired_count)
    );

    assign imem_we    = r_imem_we;
    assign imem_waddr = r_imem_waddr;
    assign imem_wdata = r_imem_wdata;
    assign core_en    = r_core_en;
    assign halted     = r_halted;
    assign halt_cause = r_halt_cause;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a fetch/imem environment and a reference model.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned IMEM_WORDS = 64;
    localparam int unsigned MAX_CYCLES = 10;
    localparam int unsigned AW         = 6;

    logic          clk;
    logic          reset;
    logic          start;
    logic          load_valid;
    logic          load_ready;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          br_taken;
    logic [31:0]   br_target;
    logic          stall;
    logic          pc_update;
    logic [31:0]   pc_new;
    logic          core_en;
    logic          halted;
    logic [1:0]    halt_cause;
    logic [31:0]   cycle_count;
    logic [31:0]   retired_count;

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .IMEM_WORDS(IMEM_WORDS),
        .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .pc           (pc),
        .instr        (instr),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .stall        (stall),
        .pc_update    (pc_update),
        .pc_new       (pc_new),
        .core_en      (core_en),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .cycle_count  (cycle_count),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Environment: fetch unit pc register and instruction memory fed by the DUT.
    logic [31:0] mem [IMEM_WORDS] = '{default: 32'h0000_0013};

    always @(posedge clk or posedge reset) begin
        if (reset) pc <= RESET_PC;
        else       pc <= pc_update ? pc_new : pc + 32'd4;
    end

    always @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
    end

    assign instr = (pc[1:0] == 2'b00 && pc < 32'(IMEM_WORDS * 4)) ? mem[pc[7:2]] : 32'h0;

    // Reference model: mode 0 idle, 1 run, 2 halt.
    int          m_mode;
    int          m_cause;
    logic [31:0] m_cyc;
    logic [31:0] m_ret;
    bit          m_we;
    logic [AW-1:0] m_waddr;
    logic [31:0] m_wdata;

    function automatic bit m_start_ok();
        return start && (m_mode != 1) && !load_valid && !m_we;
    endfunction

    function automatic int m_halt_code();
        if (m_mode != 1) return 0;
        if (!stall && ((pc % 4) != 0 || (pc / 4) >= IMEM_WORDS)) return 2;
        if (!stall && (instr == 32'h0000_0073 || instr == 32'h0010_0073)) return 1;
        if (m_cyc == 32'(MAX_CYCLES - 1)) return 3;
        return 0;
    endfunction

    task automatic m_redirect(output bit upd, output logic [31:0] npc);
        upd = 1'b1;
        npc = pc;
        if (m_mode == 0) begin
            npc = RESET_PC;
        end else if (m_mode == 2) begin
            if (m_start_ok()) npc = RESET_PC;
        end else if (m_halt_code() == 0 && !stall) begin
            if (br_taken) npc = br_target;
            else          upd = 1'b0;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        bit sok;
        bit fire;
        int hc;
        if (reset) begin
            m_mode = 0; m_cause = 0; m_cyc = 0; m_ret = 0;
            m_we = 0; m_waddr = '0; m_wdata = '0;
        end else begin
            sok  = m_start_ok();
            hc   = m_halt_code();
            fire = load_valid && (m_mode != 1);
            if (m_mode == 1) begin
                if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
                if (((hc == 0 && !stall) || hc == 1) && m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
                if (hc != 0) begin
                    m_mode  = 2;
                    m_cause = hc;
                end
            end else if (sok) begin
                m_mode = 1; m_cyc = 0; m_ret = 0; m_cause = 0;
            end
            m_we = fire;
            if (fire) begin
                m_waddr = load_addr;
                m_wdata = load_data;
            end
        end
    end

    // Compare every cycle mid-period, once inputs and outputs have settled.
    always @(negedge clk) begin
        bit          eu;
        logic [31:0] en;
        if (!reset && chk_en) begin
            m_redirect(eu, en);
            check("load_ready", 32'(load_ready), 32'(m_mode != 1));
            check("pc_update", 32'(pc_update), 32'(eu));
            if (eu) check("pc_new", pc_new, en);
            check("core_en", 32'(core_en), 32'(m_mode == 1));
            check("halted", 32'(halted), 32'(m_mode == 2));
            check("halt_cause", 32'(halt_cause), 32'(m_cause));
            check("cycle_count", cycle_count, m_cyc);
            check("retired_count", retired_count, m_ret);
            check("imem_we", 32'(imem_we), 32'(m_we));
            if (m_we) begin
                check("imem_waddr", 32'(imem_waddr), 32'(m_waddr));
                check("imem_wdata", imem_wdata, m_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [31:0] prog [8] = '{
        32'h0000_0093, 32'h0010_0113, 32'h0140_0193, 32'h0020_8233,
        32'h0001_0093, 32'h0002_0113, 32'hFFF1_8193, 32'h0000_0073
    };

    initial begin
        logic [31:0] ret_before;
        reset = 1'b0; start = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
        br_taken = 1'b0; br_target = '0; stall = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_core_en", 32'(core_en), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_halt_cause", 32'(halt_cause), 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_retired", retired_count, 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_pc_new", pc_new, RESET_PC);
        step(); step();
        reset = 1'b0;
        chk_en = 1'b1;
        step();

        // Load program, let the last write land, then start.
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1; load_addr = AW'(i); load_data = prog[i];
            step();
        end
        load_valid = 1'b0;
        step();
        start = 1'b1;
        #1;
        check("start_pc_update", 32'(pc_update), 32'd1);
        check("start_pc_new", pc_new, 32'h0);
        step();
        start = 1'b0;
        check("run_core_en", 32'(core_en), 32'd1);
        check("seq_pc_update", 32'(pc_update), 32'd0);
        for (int i = 0; i < 20 && !halted; i++) step();
        check("ecall_halted", 32'(halted), 32'd1);
        check("ecall_cause", 32'(halt_cause), 32'd1);
        check("ecall_retired", retired_count, 32'd8);

        // Branch, stall-over-branch, then misaligned target fault.
        start_run();
        br_taken = 1'b1; br_target = 32'h20;
        #1;
        check("br_pc_update", 32'(pc_update), 32'd1);
        check("br_pc_new", pc_new, 32'h20);
        step();
        stall = 1'b1; br_target = 32'h40;
        #1;
        check("stall_pc_new", pc_new, 32'h20);
        ret_before = retired_count;
        step();
        check("stall_no_retire", retired_count, ret_before);
        stall = 1'b0; br_target = 32'h102;
        step();
        br_taken = 1'b0;
        step();
        check("misalign_halted", 32'(halted), 32'd1);
        check("misalign_cause", 32'(halt_cause), 32'd2);
        check("misalign_retired", retired_count, 32'd2);

        // Out-of-range pc fault.
        start_run();
        br_taken = 1'b1; br_target = 32'h100;
        step();
        br_taken = 1'b0;
        step();
        check("oor_cause", 32'(halt_cause), 32'd2);
        check("oor_retired", retired_count, 32'd1);

        // Watchdog on a self-loop.
        start_run();
        br_taken = 1'b1; br_target = 32'h0;
        repeat (9) step();
        check("wdog_not_yet", 32'(halted), 32'd0);
        step();
        br_taken = 1'b0;
        check("wdog_halted", 32'(halted), 32'd1);
        check("wdog_cycles", cycle_count, 32'd10);
        check("wdog_cause", 32'(halt_cause), 32'd3);
        step();
        start_run();
        check("restart_cycles", cycle_count, 32'd0);
        check("restart_retired", retired_count, 32'd0);
        check("restart_cause", 32'(halt_cause), 32'd0);
        check("restart_halted", 32'(halted), 32'd0);

        // Asynchronous reset in the middle of a run.
        step(); step();
        #1 reset = 1'b1;
        #1;
        check("async_core_en", 32'(core_en), 32'd0);
        check("async_cycles", cycle_count, 32'd0);
        check("async_retired", retired_count, 32'd0);
        check("async_pc_new", pc_new, RESET_PC);
        check("async_imem_we", 32'(imem_we), 32'd0);
        reset = 1'b0;
        step();

        // Start is refused while a load is requested or still landing.
        start = 1'b1; load_valid = 1'b1; load_addr = AW'(8); load_data = 32'h0000_0013;
        step();
        check("ign1_core_en", 32'(core_en), 32'd0);
        load_valid = 1'b0;
        step();
        check("ign2_core_en", 32'(core_en), 32'd0);
        step();
        start = 1'b0;
        check("late_start_core_en", 32'(core_en), 32'd1);
        step();

        // Reset drops a pending imem write.
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        step();
        load_valid = 1'b1; load_addr = AW'(9); load_data = 32'h0000_0013;
        step();
        load_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("pend_imem_we", 32'(imem_we), 32'd0);
        reset = 1'b0;
        step(); step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
